// File: rtl/muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_pkg
// Purpose  : Shared encodings for the iterative multiply/divide engine.
//            The op encodings are also used by the main control unit.
// Contents : op_e     - MULT/DIV/DIVM operation codes
//            state_e  - sequencer FSM states
//            ITERS    - number of iteration cycles per operation
// Revision : 1.0 - initial release
// ============================================================================
package muldiv_pkg;

   localparam int ITERS = 32;

   typedef enum logic [1:0] {
      OP_NONE = 2'b00,
      OP_MULT = 2'b01,
      OP_DIV  = 2'b10,
      OP_DIVM = 2'b11
   } op_e;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_LOAD   = 3'd1,
      ST_ITER   = 3'd2,
      ST_FINISH = 3'd3,
      ST_DIVZ   = 3'd4
   } state_e;

endpackage
`default_nettype wire

// File: rtl/muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_step
// Purpose  : One combinational iteration of the multiply/divide engine.
//            MULT      : Booth radix-2 step followed by an arithmetic right
//                        shift of {acc, Q, q(-1)}.
//            DIV/DIVM  : one restoring-division step on unsigned magnitudes;
//                        acc holds the partial remainder, Q the dividend
//                        bits shifting out and quotient bits shifting in.
// Ports    : op_i            operation selecting the step kind
//            acc_i / acc_o   accumulator / partial remainder
//            q_i   / q_o     multiplier / dividend-quotient register
//            qm1_i / qm1_o   Booth q(-1) bit (cleared for division)
//            m_i             multiplicand (MULT) or divisor magnitude (DIV)
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_step
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  op_e              op_i,
   input  logic [WIDTH-1:0] acc_i,
   input  logic [WIDTH-1:0] q_i,
   input  logic             qm1_i,
   input  logic [WIDTH-1:0] m_i,
   output logic [WIDTH-1:0] acc_o,
   output logic [WIDTH-1:0] q_o,
   output logic             qm1_o
);

   // One extra bit on the Booth sum so that acc - (most negative M) does
   // not overflow before the shift brings it back into range.
   logic [WIDTH:0] acc_ext;
   logic [WIDTH:0] m_ext;
   logic [WIDTH:0] booth_sum;
   logic [WIDTH:0] rem_shift;
   logic [WIDTH:0] rem_diff;

   always_comb begin
      acc_ext   = {acc_i[WIDTH-1], acc_i};
      m_ext     = {m_i[WIDTH-1], m_i};
      booth_sum = acc_ext;
      rem_shift = {acc_i, q_i[WIDTH-1]};
      rem_diff  = rem_shift - {1'b0, m_i};
      acc_o     = acc_i;
      q_o       = q_i;
      qm1_o     = qm1_i;

      if (op_i == OP_MULT) begin
         case ({q_i[0], qm1_i})
            2'b01:   booth_sum = acc_ext + m_ext;
            2'b10:   booth_sum = acc_ext - m_ext;
            default: booth_sum = acc_ext;
         endcase
         acc_o = booth_sum[WIDTH:1];
         q_o   = {booth_sum[0], q_i[WIDTH-1:1]};
         qm1_o = q_i[0];
      end else begin
         // A clear sign bit on the trial difference means the divisor fits.
         if (!rem_diff[WIDTH]) begin
            acc_o = rem_diff[WIDTH-1:0];
            q_o   = {q_i[WIDTH-2:0], 1'b1};
         end else begin
            acc_o = rem_shift[WIDTH-1:0];
            q_o   = {q_i[WIDTH-2:0], 1'b0};
         end
         qm1_o = 1'b0;
      end
   end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_sequencer
// Purpose  : Iterative signed multiply / divide engine with its own FSM.
//            IDLE -> LOAD -> ITER (ITERS cycles) -> FINISH -> IDLE, or
//            IDLE -> LOAD -> DIVZ -> IDLE for a zero divisor.
// Ports    : clk, reset_in          clock, synchronous active-high reset
//            start, op              one-cycle request and operation code
//            src_a, src_b           multiplicand/dividend, multiplier/divisor
//            busy                   operation in progress
//            done, div_zero         completion pulse, divide-by-zero pulse
//            hi_out, lo_out         result words (remainder / quotient)
//            hi_w, lo_w             HI/LO register write-enable pulses
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_sequencer #(
   parameter int WIDTH = 32,
   parameter int ITERS = WIDTH
) (
   input  logic             clk,
   input  logic             reset_in,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             busy,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             hi_w,
   output logic             lo_w
);

   import muldiv_pkg::*;

   localparam int CNT_W = $clog2(ITERS);

   state_e             state_q, state_d;
   op_e                op_q;
   logic [WIDTH-1:0]   a_q, b_q;
   logic [WIDTH-1:0]   acc_q, q_q, m_q;
   logic               qm1_q;
   logic               qneg_q, rneg_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [WIDTH-1:0]   hi_q, lo_q;

   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH-1:0]   step_acc, step_q;
   logic               step_qm1;
   logic [WIDTH-1:0]   res_hi, res_lo;
   logic               start_ok;

   // 0x80000000 maps to itself, which is the correct unsigned magnitude.
   assign a_mag    = a_q[WIDTH-1] ? -a_q : a_q;
   assign b_mag    = b_q[WIDTH-1] ? -b_q : b_q;
   assign start_ok = start && (op != 2'(OP_NONE));

   // Division results carry their signs only at the end; the iteration
   // works on magnitudes. Remainder follows the dividend's sign.
   assign res_hi = (op_q == OP_MULT) ? acc_q : (rneg_q ? -acc_q : acc_q);
   assign res_lo = (op_q == OP_MULT) ? q_q   : (qneg_q ? -q_q   : q_q);

   muldiv_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .op_i  (op_q),
      .acc_i (acc_q),
      .q_i   (q_q),
      .qm1_i (qm1_q),
      .m_i   (m_q),
      .acc_o (step_acc),
      .q_o   (step_q),
      .qm1_o (step_qm1)
   );

   always_ff @(posedge clk) begin
      if (reset_in) begin
         state_q <= ST_IDLE;
         op_q    <= OP_NONE;
         a_q     <= '0;
         b_q     <= '0;
         acc_q   <= '0;
         q_q     <= '0;
         m_q     <= '0;
         qm1_q   <= 1'b0;
         qneg_q  <= 1'b0;
         rneg_q  <= 1'b0;
         cnt_q   <= '0;
         hi_q    <= '0;
         lo_q    <= '0;
      end else begin
         state_q <= state_d;
         case (state_q)
            ST_IDLE: begin
               if (start_ok) begin
                  op_q <= op_e'(op);
                  a_q  <= src_a;
                  b_q  <= src_b;
               end
            end
            ST_LOAD: begin
               acc_q <= '0;
               qm1_q <= 1'b0;
               cnt_q <= '0;
               if (op_q == OP_MULT) begin
                  q_q <= b_q;
                  m_q <= a_q;
               end else begin
                  q_q    <= a_mag;
                  m_q    <= b_mag;
                  qneg_q <= a_q[WIDTH-1] ^ b_q[WIDTH-1];
                  rneg_q <= a_q[WIDTH-1];
               end
            end
            ST_ITER: begin
               acc_q <= step_acc;
               q_q   <= step_q;
               qm1_q <= step_qm1;
               cnt_q <= cnt_q + CNT_W'(1);
            end
            ST_FINISH: begin
               hi_q <= res_hi;
               lo_q <= res_lo;
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_d  = state_q;
      busy     = (state_q != ST_IDLE);
      done     = 1'b0;
      div_zero = 1'b0;
      hi_w     = 1'b0;
      lo_w     = 1'b0;
      // Results are presented during FINISH so they coincide with done.
      hi_out   = hi_q;
      lo_out   = lo_q;

      case (state_q)
         ST_IDLE: begin
            if (start_ok) state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if ((op_q != OP_MULT) && (b_q == '0)) state_d = ST_DIVZ;
            else                                  state_d = ST_ITER;
         end
         ST_ITER: begin
            if (cnt_q == CNT_W'(ITERS-1)) state_d = ST_FINISH;
         end
         ST_FINISH: begin
            state_d = ST_IDLE;
            done    = 1'b1;
            hi_w    = 1'b1;
            lo_w    = 1'b1;
            hi_out  = res_hi;
            lo_out  = res_lo;
         end
         ST_DIVZ: begin
            state_d  = ST_IDLE;
            done     = 1'b1;
            div_zero = 1'b1;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_muldiv_sequencer
// Purpose  : Self-checking bench for muldiv_sequencer: a table of directed
//            MULT/DIV/DIVM vectors plus hand-written sequences for the
//            divide-by-zero, ignored-start and mid-operation reset cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_sequencer;

   logic        clk = 1'b0;
   logic        reset_in;
   logic        start;
   logic [1:0]  op;
   logic [31:0] src_a, src_b;
   logic        busy, done, div_zero, hi_w, lo_w;
   logic [31:0] hi_out, lo_out;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   typedef struct {
      logic [1:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;

   vec_t vecs [10];

   muldiv_sequencer #(.WIDTH(32), .ITERS(32)) dut (
      .clk      (clk),
      .reset_in (reset_in),
      .start    (start),
      .op       (op),
      .src_a    (src_a),
      .src_b    (src_b),
      .busy     (busy),
      .done     (done),
      .div_zero (div_zero),
      .hi_out   (hi_out),
      .lo_out   (lo_out),
      .hi_w     (hi_w),
      .lo_w     (lo_w)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   // Start is sampled at the edge ending cycle T; on return we are in T+1.
   task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(posedge clk);
      #1;
      start = 1'b0; op = 2'b00; src_a = $urandom; src_b = $urandom;
      cyc = 1;
   endtask

   // Move to the middle (falling edge) of cycle T+n.
   task automatic go_to(input int n);
      while (cyc < n) begin
         @(posedge clk);
         cyc++;
      end
      @(negedge clk);
   endtask

   initial begin
      int hits;

      vecs[0] = '{2'b01, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB};
      vecs[1] = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[2] = '{2'b10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[3] = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
      vecs[4] = '{2'b10, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
      vecs[5] = '{2'b01, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001};
      vecs[6] = '{2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
      vecs[7] = '{2'b10, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
      vecs[8] = '{2'b10, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
      vecs[9] = '{2'b10, 32'h00000451, 32'h00000020, 32'h00000011, 32'h00000022};

      reset_in = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
      repeat (3) @(posedge clk);
      #1 reset_in = 1'b0;
      @(negedge clk);
      check("reset busy",     busy,     0);
      check("reset done",     done,     0);
      check("reset div_zero", div_zero, 0);
      check("reset hi_w",     hi_w,     0);
      check("reset lo_w",     lo_w,     0);
      check("reset hi_out",   hi_out,   0);
      check("reset lo_out",   lo_out,   0);

      // op = none must not start anything
      issue(2'b00, 32'd1, 32'd2);
      go_to(1); check("opnone busy T+1", busy, 0);
      go_to(2); check("opnone busy T+2", busy, 0);

      for (int i = 0; i < 10; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b);
         go_to(1);
         check($sformatf("v%0d busy T+1", i), busy, 1);
         go_to(33);
         check($sformatf("v%0d done T+33", i), done, 0);
         go_to(34);
         check($sformatf("v%0d done", i),     done,     1);
         check($sformatf("v%0d hi_w", i),     hi_w,     1);
         check($sformatf("v%0d lo_w", i),     lo_w,     1);
         check($sformatf("v%0d div_zero", i), div_zero, 0);
         check($sformatf("v%0d hi_out", i),   hi_out,   vecs[i].hi);
         check($sformatf("v%0d lo_out", i),   lo_out,   vecs[i].lo);
         go_to(35);
         check($sformatf("v%0d busy T+35", i), busy,   0);
         check($sformatf("v%0d done T+35", i), done,   0);
         check($sformatf("v%0d hi held", i),   hi_out, vecs[i].hi);
         check($sformatf("v%0d lo held", i),   lo_out, vecs[i].lo);
      end

      // Divide by zero: HI/LO hold 0x11/0x22 from the last table vector
      issue(2'b10, 32'd5, 32'd0);
      go_to(1);
      check("divz busy T+1", busy, 1);
      check("divz done T+1", done, 0);
      go_to(2);
      check("divz div_zero", div_zero, 1);
      check("divz done",     done,     1);
      check("divz hi_w",     hi_w,     0);
      check("divz lo_w",     lo_w,     0);
      check("divz busy T+2", busy,     1);
      check("divz hi_out",   hi_out,   32'h11);
      check("divz lo_out",   lo_out,   32'h22);
      go_to(3);
      check("divz busy T+3", busy,     0);
      check("divz done T+3", done,     0);
      check("divz dz T+3",   div_zero, 0);

      // Start while busy is ignored
      issue(2'b01, 32'd3, 32'd5);
      go_to(5);
      start = 1'b1; op = 2'b10; src_a = 32'd100; src_b = 32'd7;
      @(posedge clk);
      #1 start = 1'b0; op = 2'b00;
      cyc = 6;
      go_to(34);
      check("ignore done",   done,   1);
      check("ignore hi_out", hi_out, 0);
      check("ignore lo_out", lo_out, 32'd15);
      go_to(35);
      check("ignore busy T+35", busy, 0);
      hits = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done || busy) hits++;
      end
      check("ignore no restart", hits, 0);

      // Reset in the middle of an operation
      issue(2'b01, 32'h1234, 32'h5678);
      go_to(5);
      start = 1'b1; op = 2'b10; src_a = 32'd9; src_b = 32'd4;
      @(posedge clk);
      #1 start = 1'b0; op = 2'b00;
      cyc = 6;
      go_to(12);
      reset_in = 1'b1;
      @(posedge clk);
      #1 reset_in = 1'b0;
      cyc = 13;
      go_to(13);
      check("rst busy",   busy,   0);
      check("rst done",   done,   0);
      check("rst hi_w",   hi_w,   0);
      check("rst hi_out", hi_out, 0);
      check("rst lo_out", lo_out, 0);
      hits = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (done || hi_w || lo_w || busy) hits++;
      end
      check("rst no late write", hits, 0);

      issue(2'b01, 32'd3, 32'd4);
      go_to(34);
      check("fresh done",   done,   1);
      check("fresh hi_out", hi_out, 0);
      check("fresh lo_out", lo_out, 32'd12);
      go_to(35);
      check("fresh busy T+35", busy, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/muldiv_sequencer.md
Name: muldiv_sequencer

Overview:
- Iterative multiply/divide engine with its own sequencing FSM. Executes MULT, DIV and DIVM on 32-bit signed operands and delivers the 64-bit result to the HI/LO registers.
- Sits beside the ALU in the multicycle datapath. The main control unit issues a one-cycle start and waits on done; it reads div_zero to take the divide-by-zero exception path.
- Source operands come from the A/B registers (DIV/MULT) or the memory-data path (DIVM). Selection happens upstream; inside this block DIVM is identical to DIV.

Parameters:
- WIDTH, 32, operand width; result is 2*WIDTH.
- ITERS, 32, iteration count; always equals WIDTH.

Ports:
- clk  in  1  system clock, rising edge
- reset_in  in  1  synchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- op  in  2  00 none, 01 MULT, 10 DIV, 11 DIVM
- src_a  in  32  multiplicand / dividend
- src_b  in  32  multiplier / divisor
- busy  out  1  high from the cycle after an accepted start until the cycle after done
- done  out  1  one-cycle completion pulse
- div_zero  out  1  one-cycle pulse, coincident with done, when the divisor is 0
- hi_out  out  32  result high word (remainder for DIV); held until the next successful completion
- lo_out  out  32  result low word (quotient for DIV)
- hi_w  out  1  HI register write enable; one-cycle pulse
- lo_w  out  1  LO register write enable; one-cycle pulse

Behaviour:
- Interface decision: one clock (clk); reset is synchronous and active-high (reset_in).
- Reset: all outputs are 0, including hi_out and lo_out. The FSM enters IDLE and the counter is 0.
- States: IDLE, LOAD, ITER, FINISH, DIVZ.
- IDLE: start=1 with op≠00 latches op, src_a and src_b, then goes to LOAD. start with op=00 is ignored.
- LOAD (1 cycle):
  - MULT: initialise Booth radix-2 registers. Accumulator = 0, Q = src_b, q(-1) = 0.
  - DIV/DIVM with src_b==0: go to DIVZ.
  - DIV/DIVM otherwise: take magnitudes of both operands, record the quotient sign (sign_a XOR sign_b) and the remainder sign (sign_a), clear the remainder register.
  - counter = 0; then go to ITER.
- ITER (exactly ITERS cycles, counter 0..31):
  - MULT: one Booth step per cycle (add, subtract or nothing per {Q0, q(-1)}), followed by an arithmetic right shift of {acc, Q, q(-1)}.
  - DIV: one restoring-division step per cycle on the magnitudes.
  - Leave ITER when counter==31.
- FINISH (1 cycle):
  - MULT: hi_out = acc, lo_out = Q.
  - DIV: apply sign fix-ups; lo_out = quotient, hi_out = remainder. The remainder takes the dividend's sign.
  - done=1, hi_w=1, lo_w=1. Next state is IDLE.
- DIVZ (1 cycle): div_zero=1, done=1, hi_w=0, lo_w=0. hi_out and lo_out are unchanged. Next state is IDLE.
- Latency, with start sampled at the edge ending cycle T:
  - LOAD occupies T+1, ITER occupies T+2..T+33, FINISH occupies T+34.
  - DIVZ occupies T+2.
  - busy is high T+1..T+34 on the normal path, and T+1..T+2 on the divide-by-zero path.
- Arithmetic rules:
  - Products are full 64-bit signed with no overflow; 0x80000000 * 0x80000000 = 0x4000000000000000.
  - 0x80000000 / 0xFFFFFFFF yields quotient 0x80000000 (wraps) and remainder 0; no exception is raised.
  - Division truncates toward zero.
- start while busy is ignored. Operands and op are not re-latched.
- reset_in mid-operation takes priority over every state. The next cycle is IDLE with all outputs 0; no HI/LO write or done is emitted.
- Registered inputs are used throughout; src_a and src_b may change after the start cycle.

Decomposition:
- muldiv_pkg holds:
  - op encodings OP_NONE, OP_MULT, OP_DIV, OP_DIVM;
  - state encodings ST_IDLE, ST_LOAD, ST_ITER, ST_FINISH, ST_DIVZ;
  - the ITERS constant.
- The main control unit shares the op encodings from this package.
- One combinational sub-module, muldiv_step, performs a single Booth step or restoring-division step, selected by op. The FSM, counter and registers stay in muldiv_sequencer.

Test Plan:
- MULT 7 * 0xFFFFFFFD (-3) → at T+34: done=1, hi_w=lo_w=1, hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB; busy low at T+35.
- MULT 0x80000000 * 0x80000000 → hi_out=0x40000000, lo_out=0x00000000.
- DIV 0xFFFFFFF9 (-7) / 2 → lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1); DIVM with the same operands gives identical results.
- DIV 5 / 0, with hi_out/lo_out previously 0x11/0x22 → at T+2: div_zero=1, done=1, hi_w=lo_w=0; hi_out=0x11 and lo_out=0x22 are unchanged; IDLE at T+3.
- DIV 0x80000000 / 0xFFFFFFFF → lo_out=0x80000000, hi_out=0, div_zero=0.
- Start MULT, pulse start again with new operands at T+5, then assert reset_in at T+12:
  - the second start is ignored;
  - after reset, busy=0, done=0 and hi_w=0 on the following cycle, and hi_out=lo_out=0;
  - a fresh MULT 3*4 then gives lo_out=12 at its own T+34.
